mx12_ins_prefetch: RTL

Parametrised successor to the MX11 single-shot instruction fetch: a decoupled prefetch unit that keeps a QDEPTH-entry instruction queue filled over the MX bus read-master port. It owns its own fetch pointer, is redirected from register line entry INSP_INDEX, and hands instruction words plus their addresses to decode with a valid/consume handshake. It sits between the register bus, the MX bus arbiter and the decode/load stage.

---
 rtl/mx12_pf_pkg.sv | 21 ++
 rtl/mx12_pf_fifo.sv | 62 ++++++
 rtl/mx12_ins_prefetch.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mx12_pf_pkg.sv
// mx12_pf_pkg: shared types and constants for the MX12 instruction prefetch unit.
package mx12_pf_pkg;

  // Bus-side fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_CPL  = 2'd3
  } pf_state_e;

  localparam pf_state_e STATE_RST   = ST_IDLE;
  localparam logic      STALE_RST   = 1'b0;
  localparam int unsigned STALL_CNT_W = 16;

  // Saturating increment for the consume-stall counter.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == '1) ? v : v + STALL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mx12_pf_fifo.sv
// mx12_pf_fifo: shift-register queue; entry 0 is always the head, so the
// head output comes straight from a flop. Flush beats push and pop.
module mx12_pf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0][WIDTH-1:0] mem_d;
  logic [CW-1:0]               cnt_mid;
  logic [CW-1:0]               cnt_d;
  logic [IW-1:0]               wr_idx;
  logic                        do_pop;
  logic                        do_push;

  assign head = mem_q[0];

  // Next queue contents: pop shifts toward the head, push lands behind the survivors.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CW'(DEPTH)) || do_pop);
    cnt_mid = do_pop ? count - CW'(1) : count;
    wr_idx  = IW'(cnt_mid);
    mem_d   = do_pop ? (mem_q >> WIDTH) : mem_q;
    cnt_d   = cnt_mid;
    if (do_push) begin
      mem_d[wr_idx] = din;
      cnt_d         = cnt_mid + CW'(1);
    end
    if (flush) begin
      mem_d = '0;
      cnt_d = '0;
    end
  end

  // Queue storage, occupancy and non-empty flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      mem_q <= mem_d;
      count <= cnt_d;
      valid <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/mx12_ins_prefetch.sv
// mx12_ins_prefetch: decoupled instruction prefetch keeping a QDEPTH-entry queue
// filled over the MX bus read-master port, one outstanding read at a time.
// Optional feature: define MX12_PF_STALL_CNT_EN to add the stall_cnt output.
module mx12_ins_prefetch
  import mx12_pf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned REGBUS_WIDTH = 16,
  parameter int unsigned QDEPTH       = 4,
  parameter int unsigned INSP_INDEX   = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [REGBUS_WIDTH-1:0][DATA_WIDTH-1:0] reg_line,
  output logic                                   ins_rd_txn_start,
  output logic [ADDR_WIDTH-1:0]                  ins_rd_addr,
  input  logic                                   ins_rd_txn_ack,
  input  logic                                   ins_rd_ready,
  input  logic [DATA_WIDTH-1:0]                  ins_rd_data,
  input  logic                                   ins_rd_txn_cpl,
  input  logic                                   fetch_en,
  input  logic                                   redirect,
  input  logic                                   consume,
  output logic [DATA_WIDTH-1:0]                  insr,
  output logic [ADDR_WIDTH-1:0]                  insr_addr,
  output logic                                   insr_valid,
  output logic [$clog2(QDEPTH):0]                q_count
`ifdef MX12_PF_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]                 stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned EW = DATA_WIDTH + ADDR_WIDTH;

  pf_state_e             state;
  logic                  stale;
  logic [ADDR_WIDTH-1:0] fetch_ptr;
  logic [ADDR_WIDTH-1:0] insp;
  logic                  room;
  logic                  push;
  logic [EW-1:0]         head;
  logic                  unused_reg_bits;

  // Instruction pointer tap from the register bus.
  assign insp            = ADDR_WIDTH'(reg_line[INSP_INDEX]);
  assign unused_reg_bits = ^reg_line;

  // Every request reserves a slot; only one can be outstanding.
  assign room = (q_count < CW'(QDEPTH));
  assign push = (state == ST_DATA) && ins_rd_ready && !stale && !redirect;

  mx12_pf_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (consume),
    .flush (redirect),
    .din   ({ins_rd_data, ins_rd_addr}),
    .head  (head),
    .valid (insr_valid),
    .count (q_count)
  );

  assign insr      = head[EW-1 -: DATA_WIDTH];
  assign insr_addr = head[ADDR_WIDTH-1:0];

  // Fetch sequencer: request, ack, data, completion; redirect marks an in-flight read stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= STATE_RST;
      stale            <= STALE_RST;
      fetch_ptr        <= '0;
      ins_rd_txn_start <= 1'b0;
      ins_rd_addr      <= '0;
    end else begin
      if (redirect) begin
        fetch_ptr <= insp;
      end else if (push) begin
        fetch_ptr <= fetch_ptr + ADDR_WIDTH'(1);
      end
      case (state)
        ST_IDLE: begin
          if (fetch_en && (redirect || room)) begin
            state            <= ST_REQ;
            ins_rd_txn_start <= 1'b1;
            ins_rd_addr      <= redirect ? insp : fetch_ptr;
          end
        end
        ST_REQ: begin
          if (redirect) stale <= 1'b1;
          if (ins_rd_txn_ack) begin
            ins_rd_txn_start <= 1'b0;
            state            <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (redirect) stale <= 1'b1;
          if (ins_rd_ready) begin
            if (ins_rd_txn_cpl) begin
              state <= ST_IDLE;
              stale <= 1'b0;
            end else begin
              state <= ST_CPL;
            end
          end
        end
        ST_CPL: begin
          if (redirect) stale <= 1'b1;
          if (ins_rd_txn_cpl) begin
            state <= ST_IDLE;
            stale <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MX12_PF_STALL_CNT_EN
  // Cycles decode asked for an instruction that was not there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (redirect) begin
      stall_cnt <= '0;
    end else if (consume && !insr_valid) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule
